// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the multi-channel NCO.
//   - wave_sel_e    : waveform select encoding
//   - DEF_*         : default widths used by nco_multi / nco_channel
//   - sine_lut_entry: quarter-wave sine table generator (elaboration-time only)
package nco_pkg;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_PHASE_WIDTH    = 16;
    localparam int DEF_WAVE_WIDTH     = 8;
    localparam int DEF_SELECT_WIDTH   = 3;
    localparam int DEF_LUT_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        WAVE_OFF    = 3'd0,
        WAVE_SINE   = 3'd1,
        WAVE_SQUARE = 3'd2,
        WAVE_TRI    = 3'd3,
        WAVE_SAW    = 3'd4
    } wave_sel_e;

    // Magnitude of quarter-wave entry idx, sampled at bin centres so the
    // table is symmetric under the address inversion used for quadrants 1/3.
    // Result is always non-negative, so +0.5 then truncate rounds to nearest.
    function automatic int sine_lut_entry(input int idx, input int addr_w, input int wave_w);
        real amp;
        real ang;
        amp = real'((1 << (wave_w - 1)) - 1);
        ang = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_channel.sv
// nco_channel: one NCO lane.
//   Holds the channel's config (ftw, phase offset, select), its phase
//   accumulator and a 2-stage output pipeline:
//     stage 1: phase_q   <= acc_q + offset
//     stage 2: wave_q    <= waveform(sel, phase_q)
// Ports:
//   clk, rst_n       clock / async active-low reset
//   wr_i             config write hit for this channel
//   clr_i            clear accumulator together with the write
//   sync_i           global phase alignment (acc cleared, overrides all)
//   en_i             run enable
//   ftw_i/off_i/sel_i config values loaded on wr_i
//   wave_o, valid_o  output sample and its valid
module nco_channel
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int WAVE_WIDTH     = DEF_WAVE_WIDTH,
    parameter int SELECT_WIDTH   = DEF_SELECT_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_i,
    input  logic                    clr_i,
    input  logic                    sync_i,
    input  logic                    en_i,
    input  logic [PHASE_WIDTH-1:0]  ftw_i,
    input  logic [PHASE_WIDTH-1:0]  off_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    output logic [WAVE_WIDTH-1:0]   wave_o,
    output logic                    valid_o
);

    localparam int STAGES = 2;
    localparam int MSB    = PHASE_WIDTH - 1;
    localparam int LUT_N  = 1 << LUT_ADDR_WIDTH;
    localparam logic [WAVE_WIDTH-1:0] MID  = WAVE_WIDTH'(1 << (WAVE_WIDTH - 1));
    localparam logic [WAVE_WIDTH-1:0] FULL = {WAVE_WIDTH{1'b1}};

    typedef struct packed {
        logic [PHASE_WIDTH-1:0]  ftw;
        logic [PHASE_WIDTH-1:0]  off;
        logic [SELECT_WIDTH-1:0] sel;
    } ch_cfg_t;

    ch_cfg_t                  cfg_d,      cfg_q;
    logic [PHASE_WIDTH-1:0]   acc_d,      acc_q;
    logic [PHASE_WIDTH-1:0]   phase_d,    phase_q;
    logic [WAVE_WIDTH-1:0]    wave_d,     wave_q;
    logic [STAGES:1]          vld_pipe_d, vld_pipe_q;

    // Quarter-wave table, folded to constants at elaboration.
    logic [LUT_N-1:0][WAVE_WIDTH-1:0] lut;
    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        localparam int MAG = sine_lut_entry(i, LUT_ADDR_WIDTH, WAVE_WIDTH);
        assign lut[i] = WAVE_WIDTH'(MAG);
    end

    logic [1:0]                quad;
    logic [LUT_ADDR_WIDTH-1:0] lut_addr;
    logic [WAVE_WIDTH-1:0]     sine_mag;
    logic [WAVE_WIDTH-1:0]     tri_t;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_i) cfg_d = '{ftw: ftw_i, off: off_i, sel: sel_i};

        // Accumulate uses the ftw already registered; a new ftw takes
        // effect from the cycle after the write.
        acc_d = acc_q;
        if (sync_i)              acc_d = '0;
        else if (wr_i && clr_i)  acc_d = '0;
        else if (en_i)           acc_d = acc_q + cfg_q.ftw;

        phase_d    = acc_q + cfg_q.off;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], en_i};

        quad     = phase_q[MSB -: 2];
        lut_addr = phase_q[MSB-2 -: LUT_ADDR_WIDTH];
        // Quadrants 1 and 3 run the quarter table backwards.
        if (quad[0]) lut_addr = ~lut_addr;
        sine_mag = lut[lut_addr];
        tri_t    = phase_q[MSB-1 -: WAVE_WIDTH];

        case (cfg_q.sel)
            SELECT_WIDTH'(WAVE_SINE):   wave_d = quad[1] ? (MID - sine_mag) : (MID + sine_mag);
            SELECT_WIDTH'(WAVE_SQUARE): wave_d = phase_q[MSB] ? '0 : FULL;
            SELECT_WIDTH'(WAVE_TRI):    wave_d = phase_q[MSB] ? ~tri_t : tri_t;
            SELECT_WIDTH'(WAVE_SAW):    wave_d = phase_q[MSB -: WAVE_WIDTH];
            default:                    wave_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            wave_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            cfg_q      <= cfg_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            wave_q     <= wave_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign wave_o  = wave_q;
    assign valid_o = vld_pipe_q[STAGES];

    // Low phase bits only matter through the accumulator carry chain.
    logic unused_phase_bits;
    assign unused_phase_bits = ^phase_q;

endmodule

// File: rtl/nco_multi.sv
// nco_multi: NUM_CH independent NCO channels behind one config port.
//   Config write (cfg_valid && cfg_ready) to cfg_ch < NUM_CH loads that
//   channel's ftw / phase offset / select, optionally clearing its
//   accumulator. An out-of-range cfg_ch changes nothing and pulses cfg_err
//   for one cycle.
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   cfg_valid, cfg_ready                config handshake (ready=1 out of reset)
//   cfg_ch, cfg_ftw, cfg_phase_off,
//   cfg_sel, cfg_clr_phase              config payload
//   cfg_err                             out-of-range channel pulse
//   sync_in                             (NCO_PHASE_SYNC_EN only) clear all accs
//   enable                              per-channel run enable
//   wave_out                            lane n at [n*WAVE_WIDTH +: WAVE_WIDTH]
//   wave_valid                          per-lane sample valid
// Build option: define NCO_PHASE_SYNC_EN to add sync_in.
module nco_multi
    import nco_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter int WAVE_WIDTH     = DEF_WAVE_WIDTH,
    parameter int SELECT_WIDTH   = DEF_SELECT_WIDTH,
    parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(NUM_CH):0]      cfg_ch,
    input  logic [PHASE_WIDTH-1:0]       cfg_ftw,
    input  logic [PHASE_WIDTH-1:0]       cfg_phase_off,
    input  logic [SELECT_WIDTH-1:0]      cfg_sel,
    input  logic                         cfg_clr_phase,
    output logic                         cfg_err,
`ifdef NCO_PHASE_SYNC_EN
    input  logic                         sync_in,
`endif
    input  logic [NUM_CH-1:0]            enable,
    output logic [NUM_CH*WAVE_WIDTH-1:0] wave_out,
    output logic [NUM_CH-1:0]            wave_valid
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic              ready_d, ready_q;
    logic              err_d,   err_q;
    logic              cfg_fire;
    logic              ch_ok;
    logic [NUM_CH-1:0] wr_hit;
    logic              sync_all;

    logic [NUM_CH-1:0][WAVE_WIDTH-1:0] wave_lane;

`ifdef NCO_PHASE_SYNC_EN
    assign sync_all = sync_in;
`else
    assign sync_all = 1'b0;
`endif

    always_comb begin
        ready_d  = 1'b1;
        cfg_fire = cfg_valid && ready_q;
        ch_ok    = cfg_ch < CH_W'(NUM_CH);
        err_d    = cfg_fire && !ch_ok;
        for (int n = 0; n < NUM_CH; n++) begin
            wr_hit[n] = cfg_fire && ch_ok && (cfg_ch == CH_W'(n));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        nco_channel #(
            .PHASE_WIDTH    (PHASE_WIDTH),
            .WAVE_WIDTH     (WAVE_WIDTH),
            .SELECT_WIDTH   (SELECT_WIDTH),
            .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_i    (wr_hit[n]),
            .clr_i   (cfg_clr_phase),
            .sync_i  (sync_all),
            .en_i    (enable[n]),
            .ftw_i   (cfg_ftw),
            .off_i   (cfg_phase_off),
            .sel_i   (cfg_sel),
            .wave_o  (wave_lane[n]),
            .valid_o (wave_valid[n])
        );
    end

    assign wave_out = wave_lane;

endmodule
